// File: rtl/line_packer.sv
// line_packer: packs an 8-bit pixel stream into 128-bit period words, 21 per line.
// Optional macro PACK_MSB_FIRST_EN places the first pixel in the MSB byte lane.
module line_packer #(
  parameter int PeriodNum    = 21,
  parameter int PixPerPeriod = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic [7:0]   pixdata,
  input  logic         pixvalid,
  input  logic         pixlast,
  output logic         pixready,
  output logic [127:0] wrdata,
  output logic         wrfifo,
  input  logic         wrfull,
  output logic         errshort,
  output logic         errlong,
  output logic [1:0]   stateoutput,
  output logic [15:0]  linecounteroutput
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    WRITE = 2'd1,
    PAD   = 2'd2
  } state_t;

  localparam logic [4:0] LastPer  = 5'(PeriodNum - 1);
  localparam logic [3:0] LastByte = 4'(PixPerPeriod - 1);

  state_t         state;
  logic [3:0]     bidx;
  logic [4:0]     pidx;
  logic           padding;
  logic [15:0]    lines;
  logic [127:0]   word;
  logic           es;
  logic           el;
  logic [3:0]     lane;
  logic [6:0]     base;
  logic           last_byte;
  logic           line_end;

`ifdef PACK_MSB_FIRST_EN
  assign lane = ~bidx;
`else
  assign lane = bidx;
`endif

  assign base      = {lane, 3'b000};
  assign last_byte = (bidx == LastByte);
  assign line_end  = last_byte && (pidx == LastPer);

  assign pixready = ce & ~reset & (state == FILL);
  assign wrfifo   = ce & ~reset & (state == WRITE) & ~wrfull;

  assign wrdata            = word;
  assign errshort          = es;
  assign errlong           = el;
  assign stateoutput       = state;
  assign linecounteroutput = lines;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FILL;
      bidx    <= '0;
      pidx    <= '0;
      padding <= 1'b0;
      lines   <= '0;
      word    <= '0;
      es      <= 1'b0;
      el      <= 1'b0;
    end else begin
      es <= 1'b0;
      el <= 1'b0;
      if (ce) begin
        unique case (state)
          FILL: begin
            if (pixvalid) begin
              word[base +: 8] <= pixdata;
              bidx <= bidx + 4'd1;
              // a short line finishes the current word with pad bytes
              if (pixlast && !line_end) begin
                es      <= 1'b1;
                padding <= 1'b1;
                state   <= last_byte ? WRITE : PAD;
              end else if (last_byte) begin
                state <= WRITE;
              end
              if (line_end && !pixlast) begin
                el <= 1'b1;
              end
            end
          end
          PAD: begin
            word[base +: 8] <= 8'h00;
            bidx <= bidx + 4'd1;
            if (last_byte) begin
              state <= WRITE;
            end
          end
          WRITE: begin
            if (!wrfull) begin
              bidx <= '0;
              word <= '0;
              if (pidx == LastPer) begin
                pidx    <= '0;
                lines   <= lines + 16'd1;
                padding <= 1'b0;
                state   <= FILL;
              end else begin
                pidx  <= pidx + 5'd1;
                state <= padding ? PAD : FILL;
              end
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_packer.sv
// tb_line_packer: directed stimulus with a word scoreboard for line_packer.
// Build with PACK_MSB_FIRST_EN to check the MSB-first lane order.
module tb_line_packer;

  logic         clk;
  logic         reset;
  logic         ce;
  logic [7:0]   pixdata;
  logic         pixvalid;
  logic         pixlast;
  logic         pixready;
  logic [127:0] wrdata;
  logic         wrfifo;
  logic         wrfull;
  logic         errshort;
  logic         errlong;
  logic [1:0]   stateoutput;
  logic [15:0]  linecounteroutput;

  line_packer dut (
    .clk               (clk),
    .reset             (reset),
    .ce                (ce),
    .pixdata           (pixdata),
    .pixvalid          (pixvalid),
    .pixlast           (pixlast),
    .pixready          (pixready),
    .wrdata            (wrdata),
    .wrfifo            (wrfifo),
    .wrfull            (wrfull),
    .errshort          (errshort),
    .errlong           (errlong),
    .stateoutput       (stateoutput),
    .linecounteroutput (linecounteroutput)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nasrt = 0;
  int nfail = 0;

  logic [127:0] q[$];
  logic [7:0]   mb[16];
  int mbi = 0;
  int mper = 0;
  int exp_short = 0;
  int exp_long = 0;
  int exp_lines = 0;
  int es_cnt = 0;
  int el_cnt = 0;
  int wr_cnt = 0;
  logic [127:0] first_word;
  bit ce_tog = 0;
  bit ce_drive = 1;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] expv);
    nasrt++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_word();
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) begin
`ifdef PACK_MSB_FIRST_EN
      w[(15-i)*8 +: 8] = mb[i];
`else
      w[i*8 +: 8] = mb[i];
`endif
    end
    q.push_back(w);
  endtask

  task automatic model_push(input logic [7:0] v, input logic last);
    bit short_l;
    mb[mbi] = v;
    mbi++;
    short_l = last && !(mbi == 16 && mper == 20);
    if (short_l) begin
      exp_short++;
      while (mbi < 16) begin
        mb[mbi] = 8'h00;
        mbi++;
      end
    end
    if (mbi == 16) begin
      push_word();
      mbi = 0;
      if (mper == 20) begin
        mper = 0;
        exp_lines++;
        if (!last) exp_long++;
      end else begin
        mper++;
        if (short_l) begin
          for (int i = 0; i < 16; i++) mb[i] = 8'h00;
          while (mper <= 20) begin
            push_word();
            mper++;
          end
          mper = 0;
          exp_lines++;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    #4;
    if (wrfifo) begin
      chk("write_ce", ce, 1'b1);
      chk("write_notfull", wrfull, 1'b0);
      if (wr_cnt == 0) first_word = wrdata;
      wr_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_write", 1'b1, 1'b0);
      end else begin
        chk("word", wrdata, q.pop_front());
      end
    end
    if (errshort) es_cnt++;
    if (errlong) el_cnt++;
  end

  initial begin
    ce = 1'b1;
    forever begin
      @(negedge clk);
      ce = ce_tog ? ~ce : ce_drive;
    end
  end

  task automatic send_pix(input logic [7:0] v, input logic last);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    model_push(v, last);
    @(negedge clk);
    pixvalid = 1'b1;
    pixdata  = v;
    pixlast  = last;
    while (!acc) begin
      #1;
      acc = pixready;
      @(posedge clk);
      if (!acc) begin
        n++;
        if (n > 200) begin
          chk("accept_timeout", 1'b0, 1'b1);
          break;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic send_line(input int n, input int start,
                           input int step, input logic last);
    for (int i = 0; i < n; i++) begin
      send_pix(8'(start + i * step), last && (i == n - 1));
    end
    @(negedge clk);
    pixvalid = 1'b0;
    pixlast  = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q.size() != 0 || stateoutput !== 2'd0) && k < 3000) begin
      @(negedge clk);
      #4;
      k++;
    end
    repeat (2) @(negedge clk);
    #4;
    chk("drain", (k < 3000), 1'b1);
  endtask

  int w0;
  logic [127:0] ref0;

  initial begin
    reset    = 1'b1;
    pixdata  = 8'h00;
    pixvalid = 1'b0;
    pixlast  = 1'b0;
    wrfull   = 1'b0;
`ifdef PACK_MSB_FIRST_EN
    ref0 = 128'h000102030405060708090A0B0C0D0E0F;
`else
    ref0 = 128'h0F0E0D0C0B0A09080706050403020100;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pixready", pixready, 1'b0);
    chk("rst_wrfifo", wrfifo, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_state", stateoutput, 2'd0);
    chk("rst_lines", linecounteroutput, 16'd0);
    chk("rst_wrdata", wrdata, 128'd0);
    chk("rst_err", {errshort, errlong}, 2'b00);
    chk("rst_pixready_on", pixready, 1'b1);

    w0 = wr_cnt;
    send_line(336, 0, 1, 1'b1);
    drain();
    chk("t1_writes", wr_cnt - w0, 21);
    chk("t1_first", first_word, ref0);
    chk("t1_lines", linecounteroutput, 16'd1);
    chk("t1_short", es_cnt, 0);
    chk("t1_long", el_cnt, 0);

    w0 = wr_cnt;
    send_line(20, 8'hAA, 0, 1'b1);
    drain();
    chk("t2_writes", wr_cnt - w0, 21);
    chk("t2_short", es_cnt, 1);
    chk("t2_lines", linecounteroutput, 16'd2);

    w0 = wr_cnt;
    send_line(340, 0, 1, 1'b0);
    drain();
    chk("t3_writes", wr_cnt - w0, 21);
    chk("t3_long", el_cnt, 1);
    chk("t3_lines", linecounteroutput, 16'd3);
    send_line(332, 84, 1, 1'b1);
    drain();
    chk("t3_tail_writes", wr_cnt - w0, 42);
    chk("t3_tail_lines", linecounteroutput, 16'd4);
    chk("t3_errs", es_cnt + el_cnt, 2);

    wrfull = 1'b1;
    w0 = wr_cnt;
    fork
      send_line(336, 7, 3, 1'b1);
      begin
        int k;
        k = 0;
        while (stateoutput !== 2'd1 && k < 2000) begin
          @(negedge clk);
          #2;
          k++;
        end
        chk("t4_reach_write", (k < 2000), 1'b1);
        repeat (10) begin
          chk("t4_stall_wrfifo", wrfifo, 1'b0);
          chk("t4_stall_ready", pixready, 1'b0);
          @(negedge clk);
          #2;
        end
        chk("t4_no_early_write", wr_cnt - w0, 0);
        wrfull = 1'b0;
      end
    join
    drain();
    chk("t4_writes", wr_cnt - w0, 21);
    chk("t4_lines", linecounteroutput, 16'd5);

    w0 = wr_cnt;
    ce_tog = 1;
    send_line(336, 0, 1, 1'b1);
    drain();
    ce_tog = 0;
    @(negedge clk);
    chk("t5_writes", wr_cnt - w0, 21);
    chk("t5_lines", linecounteroutput, 16'd6);
    chk("t5_errs", es_cnt + el_cnt, 2);

    w0 = wr_cnt;
    send_line(57, 200, 1, 1'b0);
    drain();
    chk("t6_pre_writes", wr_cnt - w0, 3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_rst_ready", pixready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    mbi = 0;
    mper = 0;
    exp_lines = 0;
    #1;
    chk("t6_state", stateoutput, 2'd0);
    chk("t6_lines0", linecounteroutput, 16'd0);
    chk("t6_wrdata0", wrdata, 128'd0);
    chk("t6_queue", q.size(), 0);
    w0 = wr_cnt;
    wr_cnt = 0;
    send_line(336, 0, 1, 1'b1);
    drain();
    chk("t6_first", first_word, ref0);
    chk("t6_writes", wr_cnt, 21);
    chk("t6_lines", linecounteroutput, 16'd1);
    chk("t6_model_lines", linecounteroutput, 16'(exp_lines));
    chk("t6_short", es_cnt, exp_short);
    chk("t6_long", el_cnt, exp_long);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nasrt, nfail);
    $finish;
  end

endmodule
